alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; REG_W, 5, register index width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous pipeline flush.
REQ-005 in_valid / in_ready  input / output  1 / 1  upstream decode handshake.
REQ-006 in_op  input  3  ALU operation code (opADD..opRSHIFT).
REQ-007 in_rs1_val, in_rs2_val, in_imm  input  DATA_W each  register-file values and immediate.
REQ-008 in_use_imm  input  1  operand_b = in_imm instead of rs2 value.
REQ-009 in_rs1, in_rs2, in_rd  input  REG_W each  source/destination indices; in_wb_en  input  1  instruction writes rd.
REQ-010 operation  output  3; operand_a, operand_b  output  DATA_W  registered ALU inputs.
REQ-011 out_valid / out_ready  output / input  1 / 1  downstream handshake; out_rd  output  REG_W; out_wb_en  output  1.
REQ-012 alu_result  input  DATA_W  combinational ALU result for the entry currently in the output register.

Function
REQ-013 Two storage slots: output register (OR) driving ALU, and one skid slot (SK); in_ready SHALL equal !sk_valid && !flush (registered-state only, no combinational path from out_ready).
REQ-014 Accept = in_valid && in_ready; drain = out_valid && out_ready.
REQ-015 On accept with OR empty or draining and SK empty: instruction loads OR directly, zero added latency (out_valid next cycle).
REQ-016 On accept with OR full and not draining: instruction loads SK; on the next drain SK moves into OR and SK empties.
REQ-017 Order SHALL be preserved; SK always loads OR before any new input.
REQ-018 operand_b selection SHALL happen at OR load: in_use_imm ? imm : forwarded rs2 value; operand_a = forwarded rs1 value.
REQ-019 Last-result register (LR: lr_valid, lr_rd, lr_val) SHALL capture out_rd, out_wb_en && out_rd!=0, alu_result on every drain.
REQ-020 Forwarding at OR load, per source: if OR entry is draining with out_wb_en and out_rd==rs and rs!=0 -> alu_result; else if OR empty and lr_valid and lr_rd==rs -> lr_val; else register-file value.
REQ-021 Register x0 SHALL never be forwarded.
REQ-022 Instruction in SK SHALL store raw values and indices; forwarding applied when it moves to OR.
REQ-023 Contract: register-file values older than two instructions are correct at in_* time; block does not track deeper hazards.
REQ-024 flush=1: OR, SK and LR valid bits clear next cycle; any simultaneous accept or drain-driven load discarded; out_valid=0 in the following cycle.
REQ-025 Flush and drain in same cycle: downstream transfer completes (out_ready observed), LR not updated.
REQ-026 OR outputs SHALL hold stable while out_valid && !out_ready.
REQ-027 Throughput: one instruction per cycle when out_ready held high.

Reset
REQ-028 rst_n low asynchronously clears out_valid, sk_valid, lr_valid; operation=3'b0, operand_a=operand_b=0, out_rd=0, out_wb_en=0.
REQ-029 in_ready SHALL be 1 in first cycle after rst_n deasserts; reset mid-transfer discards all held instructions.

Verification
REQ-030 Back-to-back: ADD r1=5+3 then ADD r2=r1+r1 (rs1_val stale 0), out_ready=1 -> second issue operand_a=operand_b=8.
REQ-031 Backpressure: out_ready=0, three in_valid pulses -> two accepted, in_ready=0 on third; release -> issued in order, no loss/duplication.
REQ-032 Gap forwarding: ADD r3=7, drain, idle 2 cycles, SUB rs1=r3 (stale 1) -> operand_a=7 via LR.
REQ-033 x0: ADD rd=0 result 9, next rs1=0 with rs1_val=0 -> operand_a=0.
REQ-034 Immediate: in_use_imm=1, imm=0x10, rs2 matches forwarded rd -> operand_b=0x10.
REQ-035 Flush with OR and SK full -> out_valid=0 next cycle, in_ready=1, subsequent rs match to flushed rd not forwarded.

Source files
------------

// File: rtl/alu_issue_if.sv
// Handshake bundle between decode, the ALU issue stage and the downstream ALU/writeback.
// slave = issue stage, master = surrounding environment.
`default_nettype none

interface alu_issue_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  // Upstream decode side
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_rs1_val;
  logic [DATA_W-1:0] in_rs2_val;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [REG_W-1:0]  in_rd;
  logic              in_wb_en;

  // Downstream ALU side
  logic [2:0]        operation;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              out_valid;
  logic              out_ready;
  logic [REG_W-1:0]  out_rd;
  logic              out_wb_en;
  logic [DATA_W-1:0] alu_result;

  modport slave (
    input  in_valid, in_op, in_rs1_val, in_rs2_val, in_imm, in_use_imm,
    input  in_rs1, in_rs2, in_rd, in_wb_en,
    output in_ready,
    output operation, operand_a, operand_b, out_valid, out_rd, out_wb_en,
    input  out_ready, alu_result
  );

  modport master (
    output in_valid, in_op, in_rs1_val, in_rs2_val, in_imm, in_use_imm,
    output in_rs1, in_rs2, in_rd, in_wb_en,
    input  in_ready,
    input  operation, operand_a, operand_b, out_valid, out_rd, out_wb_en,
    output out_ready, alu_result
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue.sv
// ALU issue stage: output register plus one skid slot, with operand forwarding from
// the draining instruction and from a last-result register.
`default_nettype none

//------------------------------------------------------------------------------
// Module   : alu_issue
// Purpose  : Two-entry issue buffer feeding a combinational ALU with forwarding
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_issue #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  input  wire logic    flush,
  alu_issue_if.slave   bus
);

  // Output register (drives the ALU)
  logic              r_out_valid;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [REG_W-1:0]  r_out_rd;
  logic              r_out_wb_en;

  // Skid slot keeps raw operands; forwarding is resolved when it moves into the output register
  logic              r_sk_valid;
  logic [2:0]        r_sk_op;
  logic [DATA_W-1:0] r_sk_rs1_val;
  logic [DATA_W-1:0] r_sk_rs2_val;
  logic [DATA_W-1:0] r_sk_imm;
  logic              r_sk_use_imm;
  logic [REG_W-1:0]  r_sk_rs1;
  logic [REG_W-1:0]  r_sk_rs2;
  logic [REG_W-1:0]  r_sk_rd;
  logic              r_sk_wb_en;

  // Last drained result
  logic              r_lr_valid;
  logic [REG_W-1:0]  r_lr_rd;
  logic [DATA_W-1:0] r_lr_val;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_drain;
  logic              w_or_free;
  logic              w_load_or;
  logic              w_load_sk;

  logic [2:0]        w_src_op;
  logic [DATA_W-1:0] w_src_rs1_val;
  logic [DATA_W-1:0] w_src_rs2_val;
  logic [DATA_W-1:0] w_src_imm;
  logic              w_src_use_imm;
  logic [REG_W-1:0]  w_src_rs1;
  logic [REG_W-1:0]  w_src_rs2;
  logic [REG_W-1:0]  w_src_rd;
  logic              w_src_wb_en;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  assign w_in_ready = !r_sk_valid && !flush;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_drain    = r_out_valid && bus.out_ready;
  assign w_or_free  = !r_out_valid || w_drain;
  // A held skid entry always wins the output register over new input
  assign w_load_or  = !flush && ((r_sk_valid && w_drain) || (w_accept && w_or_free));
  assign w_load_sk  = w_accept && !w_or_free;

  always_comb begin
    w_src_op      = bus.in_op;
    w_src_rs1_val = bus.in_rs1_val;
    w_src_rs2_val = bus.in_rs2_val;
    w_src_imm     = bus.in_imm;
    w_src_use_imm = bus.in_use_imm;
    w_src_rs1     = bus.in_rs1;
    w_src_rs2     = bus.in_rs2;
    w_src_rd      = bus.in_rd;
    w_src_wb_en   = bus.in_wb_en;
    if (r_sk_valid) begin
      w_src_op      = r_sk_op;
      w_src_rs1_val = r_sk_rs1_val;
      w_src_rs2_val = r_sk_rs2_val;
      w_src_imm     = r_sk_imm;
      w_src_use_imm = r_sk_use_imm;
      w_src_rs1     = r_sk_rs1;
      w_src_rs2     = r_sk_rs2;
      w_src_rd      = r_sk_rd;
      w_src_wb_en   = r_sk_wb_en;
    end
  end

  // Forwarding priority: draining result, then last result when the stage is empty, then register file
  always_comb begin
    w_fwd_a = w_src_rs1_val;
    if (w_drain && r_out_wb_en && (r_out_rd == w_src_rs1) && (w_src_rs1 != '0))
      w_fwd_a = bus.alu_result;
    else if (!r_out_valid && r_lr_valid && (r_lr_rd == w_src_rs1) && (w_src_rs1 != '0))
      w_fwd_a = r_lr_val;
  end

  always_comb begin
    w_fwd_b = w_src_rs2_val;
    if (w_drain && r_out_wb_en && (r_out_rd == w_src_rs2) && (w_src_rs2 != '0))
      w_fwd_b = bus.alu_result;
    else if (!r_out_valid && r_lr_valid && (r_lr_rd == w_src_rs2) && (w_src_rs2 != '0))
      w_fwd_b = r_lr_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_op         <= 3'b0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_out_rd     <= '0;
      r_out_wb_en  <= 1'b0;
      r_sk_valid   <= 1'b0;
      r_sk_op      <= 3'b0;
      r_sk_rs1_val <= '0;
      r_sk_rs2_val <= '0;
      r_sk_imm     <= '0;
      r_sk_use_imm <= 1'b0;
      r_sk_rs1     <= '0;
      r_sk_rs2     <= '0;
      r_sk_rd      <= '0;
      r_sk_wb_en   <= 1'b0;
      r_lr_valid   <= 1'b0;
      r_lr_rd      <= '0;
      r_lr_val     <= '0;
    end else if (flush) begin
      // A drain in this cycle still completes downstream, but its result is not remembered
      r_out_valid <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_lr_valid  <= 1'b0;
    end else begin
      if (w_drain) begin
        r_lr_valid <= r_out_wb_en && (r_out_rd != '0);
        r_lr_rd    <= r_out_rd;
        r_lr_val   <= bus.alu_result;
      end

      if (w_load_or) begin
        r_out_valid <= 1'b1;
        r_op        <= w_src_op;
        r_opa       <= w_fwd_a;
        r_opb       <= w_src_use_imm ? w_src_imm : w_fwd_b;
        r_out_rd    <= w_src_rd;
        r_out_wb_en <= w_src_wb_en;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      if (w_load_sk) begin
        r_sk_valid   <= 1'b1;
        r_sk_op      <= bus.in_op;
        r_sk_rs1_val <= bus.in_rs1_val;
        r_sk_rs2_val <= bus.in_rs2_val;
        r_sk_imm     <= bus.in_imm;
        r_sk_use_imm <= bus.in_use_imm;
        r_sk_rs1     <= bus.in_rs1;
        r_sk_rs2     <= bus.in_rs2;
        r_sk_rd      <= bus.in_rd;
        r_sk_wb_en   <= bus.in_wb_en;
      end else if (r_sk_valid && w_drain) begin
        r_sk_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.operation = r_op;
  assign bus.operand_a = r_opa;
  assign bus.operand_b = r_opb;
  assign bus.out_valid = r_out_valid;
  assign bus.out_rd    = r_out_rd;
  assign bus.out_wb_en = r_out_wb_en;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed instructions with hand-computed issued operands.
`default_nettype none

module tb_alu_issue;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_LSH = 3'd5, OP_RSH = 3'd6;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] rd;
    logic          wb;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  alu_issue_if #(.DATA_W(DW), .REG_W(RW)) bus ();

  alu_issue #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_LSH:  return a << b[4:0];
      OP_RSH:  return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.operation, bus.operand_a, bus.operand_b);

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every downstream transfer is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t got, e;
      got = {bus.operation, bus.operand_a, bus.operand_b, bus.out_rd, bus.out_wb_en};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got op=%0d a=%0h b=%0h rd=%0d", got.op, got.a, got.b, got.rd);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL issue_rd%0d: got op=%0d a=%0h b=%0h rd=%0d wb=%0b want op=%0d a=%0h b=%0h rd=%0d wb=%0b",
                   e.rd, got.op, got.a, got.b, got.rd, got.wb, e.op, e.a, e.b, e.rd, e.wb);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs1, input logic [DW-1:0] v1,
                       input logic [RW-1:0] rs2, input logic [DW-1:0] v2,
                       input logic use_imm, input logic [DW-1:0] imm);
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs1_val = v1;
    bus.in_rs2     = rs2;
    bus.in_rs2_val = v2;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
    bus.in_wb_en   = 1'b1;
    bus.in_valid   = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL accept_timeout_%s: got in_ready=0 want 1", name);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input string name, input logic [2:0] op, input logic [RW-1:0] rd,
                      input logic [RW-1:0] rs1, input logic [DW-1:0] v1,
                      input logic [RW-1:0] rs2, input logic [DW-1:0] v2,
                      input logic use_imm, input logic [DW-1:0] imm,
                      input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b);
    drive(op, rd, rs1, v1, rs2, v2, use_imm, imm);
    sb.push_back('{op: op, a: exp_a, b: exp_b, rd: rd, wb: 1'b1});
    wait_accept(name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_rs1_val = '0;
    bus.in_rs2_val = '0;
    bus.in_imm     = '0;
    bus.in_use_imm = 1'b0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rd      = '0;
    bus.in_wb_en   = 1'b0;
    bus.out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_operation", 32'(bus.operation), 32'd0);
    check("rst_operand_a", bus.operand_a,      32'd0);
    check("rst_operand_b", bus.operand_b,      32'd0);
    check("rst_out_rd",    32'(bus.out_rd),    32'd0);
    check("rst_out_wb_en", 32'(bus.out_wb_en), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: r2 = r1 + r1 with stale register values
    send("add_r1", OP_ADD, 5'd1, 5'd4, 32'd5, 5'd5, 32'd3, 1'b0, 32'd0, 32'd5, 32'd3);
    send("add_r2", OP_ADD, 5'd2, 5'd1, 32'd0, 5'd1, 32'd0, 1'b0, 32'd0, 32'd8, 32'd8);
    idle(2);

    // Gap forwarding through the last-result register
    send("add_r3", OP_ADD, 5'd3, 5'd6, 32'd7, 5'd7, 32'd0, 1'b0, 32'd0, 32'd7, 32'd0);
    idle(3);
    send("sub_r4", OP_SUB, 5'd4, 5'd3, 32'd1, 5'd8, 32'd2, 1'b0, 32'd0, 32'd7, 32'd2);
    idle(2);

    // Writes to x0 are never forwarded
    send("add_x0", OP_ADD, 5'd0, 5'd9, 32'd4, 5'd10, 32'd5, 1'b0, 32'd0, 32'd4, 32'd5);
    send("use_x0", OP_ADD, 5'd5, 5'd0, 32'd0, 5'd11, 32'd1, 1'b0, 32'd0, 32'd0, 32'd1);
    idle(2);

    // Immediate overrides a forwardable rs2; following ops chain through forwarding
    send("add_r6", OP_ADD, 5'd6, 5'd12, 32'd2, 5'd13, 32'd3, 1'b0, 32'd0, 32'd2, 32'd3);
    send("or_imm", OP_OR,  5'd9, 5'd14, 32'd1, 5'd6, 32'd0, 1'b1, 32'h10, 32'd1, 32'h10);
    send("xor_r7", OP_XOR, 5'd7, 5'd15, 32'hF0, 5'd9, 32'd0, 1'b0, 32'd0, 32'hF0, 32'h11);
    send("lsh_r8", OP_LSH, 5'd8, 5'd7, 32'd0, 5'd20, 32'd4, 1'b0, 32'd0, 32'hE1, 32'd4);
    idle(3);

    // Backpressure: two accepted, third blocked, then released in order
    bus.out_ready = 1'b0;
    send("bp_a", OP_ADD, 5'd10, 5'd16, 32'd1, 5'd17, 32'd2, 1'b0, 32'd0, 32'd1, 32'd2);
    send("bp_b", OP_SUB, 5'd11, 5'd10, 32'd0, 5'd18, 32'd1, 1'b0, 32'd0, 32'd3, 32'd1);
    drive(OP_AND, 5'd12, 5'd11, 32'd0, 5'd19, 32'hFF, 1'b0, 32'd0);
    sb.push_back('{op: OP_AND, a: 32'd2, b: 32'hFF, rd: 5'd12, wb: 1'b1});
    @(negedge clk);
    check("bp_third_blocked", 32'(bus.in_ready), 32'd0);
    check("bp_held_rd",       32'(bus.out_rd),   32'd10);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_accept("bp_c");
    idle(3);

    // Flush with both slots occupied
    bus.out_ready = 1'b0;
    drive(OP_ADD, 5'd13, 5'd21, 32'd1, 5'd22, 32'd1, 1'b0, 32'd0);
    wait_accept("fl_d");
    drive(OP_ADD, 5'd14, 5'd23, 32'd2, 5'd24, 32'd2, 1'b0, 32'd0);
    wait_accept("fl_e");
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send("post_flush", OP_ADD, 5'd15, 5'd13, 32'h22, 5'd14, 32'h33, 1'b0, 32'd0, 32'h22, 32'h33);
    idle(3);

    // Asynchronous reset mid-transfer discards the held instruction and the last result
    bus.out_ready = 1'b0;
    drive(OP_ADD, 5'd18, 5'd25, 32'd9, 5'd26, 32'd9, 1'b0, 32'd0);
    wait_accept("rst_g");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send("post_rst", OP_RSH, 5'd17, 5'd15, 32'h100, 5'd18, 32'h2, 1'b0, 32'd0, 32'h100, 32'h2);

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
